// File: rtl/cd_config_master.sv
// Clock-divider configuration bus initiator.
// Accepts one host write, issues a single c_valid beat to the UART or VGA divider,
// follows the target's ready drop/rise handshake and reports done/error to the host.
module cd_config_master #(
  parameter int               WIDTH_CONFIG_ADDR   = 2,
  parameter int               WIDTH_CONFIG_DATA   = 8,
  parameter logic [WIDTH_CONFIG_ADDR-1:0] UART_BAUDRATE_ADDR  = 2'b01,
  parameter logic [WIDTH_CONFIG_ADDR-1:0] VGA_RESOLUTION_ADDR = 2'b10,
  parameter int               TIMEOUT_CYCLES      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [WIDTH_CONFIG_ADDR-1:0] req_addr,
  input  logic [WIDTH_CONFIG_DATA-1:0] req_data,
  output logic                         resp_done,
  output logic                         resp_err,
  output logic [1:0]                   resp_code,
  output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
  output logic [WIDTH_CONFIG_DATA-1:0] c_data,
  output logic                         c_valid,
  input  logic                         c_UART_ready,
  input  logic                         c_VGA_ready
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CODE_OK       = 2'b00;
  localparam logic [1:0] CODE_BAD_ADDR = 2'b01;
  localparam logic [1:0] CODE_ACK_TO   = 2'b10;
  localparam logic [1:0] CODE_DONE_TO  = 2'b11;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_e;

  state_e                         state_q, state_d;
  logic [WIDTH_CONFIG_ADDR-1:0]   addr_q, addr_d;
  logic [WIDTH_CONFIG_DATA-1:0]   data_q, data_d;
  logic [TW-1:0]                  timer_q, timer_d;
  logic                           resp_done_q, resp_done_d;
  logic                           resp_err_q, resp_err_d;
  logic [1:0]                     resp_code_q, resp_code_d;
  logic                           sel_rdy;

  // Only the addressed target's ready matters; the other one is ignored.
  assign sel_rdy = (addr_q == UART_BAUDRATE_ADDR) ? c_UART_ready : c_VGA_ready;

  // Next-state, latch and response logic; responses are one-cycle pulses.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    timer_d     = timer_q;
    resp_done_d = 1'b0;
    resp_err_d  = 1'b0;
    resp_code_d = resp_code_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          data_d = req_data;
          if (req_addr == UART_BAUDRATE_ADDR || req_addr == VGA_RESOLUTION_ADDR) begin
            state_d = SEND;
          end else begin
            resp_err_d  = 1'b1;
            resp_code_d = CODE_BAD_ADDR;
          end
        end
      end
      SEND: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // Ack (ready low) takes priority over an expiring timer.
        if (!sel_rdy) begin
          state_d = WAIT_DONE;
          timer_d = '0;
        end else if (timer_q == T_LAST) begin
          state_d     = IDLE;
          timer_d     = '0;
          resp_err_d  = 1'b1;
          resp_code_d = CODE_ACK_TO;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (sel_rdy) begin
          state_d     = IDLE;
          timer_d     = '0;
          resp_done_d = 1'b1;
          resp_code_d = CODE_OK;
        end else if (timer_q == T_LAST) begin
          state_d     = IDLE;
          timer_d     = '0;
          resp_err_d  = 1'b1;
          resp_code_d = CODE_DONE_TO;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset aborts any write silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      timer_q     <= '0;
      resp_done_q <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_code_q <= CODE_OK;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      timer_q     <= timer_d;
      resp_done_q <= resp_done_d;
      resp_err_q  <= resp_err_d;
      resp_code_q <= resp_code_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign c_valid   = (state_q == SEND);
  assign c_addr    = c_valid ? addr_q : '0;
  assign c_data    = c_valid ? data_q : '0;
  assign resp_done = resp_done_q;
  assign resp_err  = resp_err_q;
  assign resp_code = resp_code_q;

endmodule
